ps2_keyboard_rx: RTL and testbench

PS/2 keyboard receiver and scancode decoder inside top_vga. It runs in the clk100MHz domain and takes the raw PS2Clk/PS2Data pin levels as inputs. It deserialises 11-bit device-to-host frames and decodes the F0 (break) and E0 (extended) prefixes into key events. It also produces the flap pulse and the space-held level that the game logic consumes. The block only reads the PS/2 lines and never drives them; the top leaves both inout pins in high-Z.

---
 rtl/ps2_pkg.sv | 15 +
 rtl/ps2_line_filter.sv | 46 ++++
 rtl/ps2_keyboard_rx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and scancode constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_SPACE = 8'h29;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stability filter for one raw PS/2 line.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    // The counter only runs while the synchronised level disagrees with the
    // filtered one, so any run shorter than FILTER_LEN samples is discarded.
    always_comb begin
        sync_d = {sync_q[0], raw};
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host frame receiver with F0/E0 prefix decoding and the
// flap / space-held outputs used by the game logic.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic       flap_pulse,
    output logic       space_held
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic clk_filt, data_filt, fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk  (clk),
        .rst  (rst),
        .raw  (ps2_clk),
        .filt (clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk  (clk),
        .rst  (rst),
        .raw  (ps2_data),
        .filt (data_filt)
    );

    rx_state_t     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic          clk_prev_q, clk_prev_d;
    logic [7:0]    byte_q, byte_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          break_flag_q, break_flag_d;
    logic          ext_flag_q, ext_flag_d;
    logic [7:0]    key_code_q, key_code_d;
    logic          key_ext_q, key_ext_d;
    logic          key_break_q, key_break_d;
    logic          key_valid_q, key_valid_d;
    logic          flap_q, flap_d;
    logic          space_held_q, space_held_d;

    assign fall = clk_prev_q & ~clk_filt;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        timeout_d    = timeout_q;
        clk_prev_d   = clk_filt;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        break_flag_d = break_flag_q;
        ext_flag_d   = ext_flag_q;
        key_code_d   = key_code_q;
        key_ext_d    = key_ext_q;
        key_break_d  = key_break_q;
        key_valid_d  = 1'b0;
        flap_d       = 1'b0;
        space_held_d = space_held_q;

        // A falling edge always wins over an expiring timeout.
        if (fall) begin
            timeout_d = '0;
            case (state_q)
                IDLE: begin
                    if (!data_filt) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d   = {data_filt, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = data_filt;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_filt && (^{shift_q, parity_q})) begin
                        byte_d       = shift_q;
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d     = IDLE;
                timeout_d   = '0;
                frame_err_d = 1'b1;
            end else begin
                timeout_d = timeout_q + TW'(1);
            end
        end

        if (frame_err_q) begin
            break_flag_d = 1'b0;
            ext_flag_d   = 1'b0;
        end else if (byte_valid_q) begin
            if (byte_q == SC_BREAK) begin
                break_flag_d = 1'b1;
            end else if (byte_q == SC_EXT) begin
                ext_flag_d = 1'b1;
            end else begin
                key_valid_d  = 1'b1;
                key_code_d   = byte_q;
                key_ext_d    = ext_flag_q;
                key_break_d  = break_flag_q;
                break_flag_d = 1'b0;
                ext_flag_d   = 1'b0;
                if (byte_q == SC_SPACE && !ext_flag_q) begin
                    flap_d       = ~break_flag_q;
                    space_held_d = ~break_flag_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            timeout_q    <= '0;
            clk_prev_q   <= 1'b1;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_flag_q <= 1'b0;
            ext_flag_q   <= 1'b0;
            key_code_q   <= 8'h00;
            key_ext_q    <= 1'b0;
            key_break_q  <= 1'b0;
            key_valid_q  <= 1'b0;
            flap_q       <= 1'b0;
            space_held_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            timeout_q    <= timeout_d;
            clk_prev_q   <= clk_prev_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            break_flag_q <= break_flag_d;
            ext_flag_q   <= ext_flag_d;
            key_code_q   <= key_code_d;
            key_ext_q    <= key_ext_d;
            key_break_q  <= key_break_d;
            key_valid_q  <= key_valid_d;
            flap_q       <= flap_d;
            space_held_q <= space_held_d;
        end
    end

    assign byte_out   = byte_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;
    assign key_code   = key_code_q;
    assign key_ext    = key_ext_q;
    assign key_break  = key_break_q;
    assign key_valid  = key_valid_q;
    assign flap_pulse = flap_q;
    assign space_held = space_held_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: stimulus pushes expected frame and key
// results, a negedge monitor pops and compares whenever the DUT pulses.
module tb_ps2_keyboard_rx;

    localparam int TB_FILTER  = 8;
    localparam int TB_TIMEOUT = 2000;
    localparam int HALF       = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_err;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_valid;
    logic       flap_pulse;
    logic       space_held;

    typedef struct packed {
        logic       err;
        logic [7:0] b;
    } frame_exp_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       flap;
        logic       held;
    } key_exp_t;

    frame_exp_t fq[$];
    key_exp_t   kq[$];

    int n_compared   = 0;
    int n_mismatched = 0;

    logic m_brk  = 1'b0;
    logic m_ext  = 1'b0;
    logic m_held = 1'b0;

    ps2_keyboard_rx #(
        .FILTER_LEN     (TB_FILTER),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_break  (key_break),
        .key_valid  (key_valid),
        .flap_pulse (flap_pulse),
        .space_held (space_held)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reportUnexpected(input string name);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: got pulse, expected none at %0t", name, $time);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBit(input logic b, input logic glitch);
        ps2_data = b;
        waitCycles(HALF);
        ps2_clk = 1'b0;
        waitCycles(HALF);
        ps2_clk = 1'b1;
        if (glitch) begin
            waitCycles(HALF / 2);
            ps2_clk = 1'b0;
            waitCycles(3);
            ps2_clk = 1'b1;
            waitCycles(HALF / 2);
        end
    endtask

    // Frame bit i is sent i-th: start, 8 data LSB first, parity, stop.
    task automatic sendFrameBits(input logic [10:0] bits, input int nbits, input logic glitch);
        for (int i = 0; i < nbits; i++) begin
            sendBit(bits[i], glitch);
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] makeFrame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic modelError();
        frame_exp_t f;
        f.err = 1'b1;
        f.b   = 8'h00;
        fq.push_back(f);
        m_brk = 1'b0;
        m_ext = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic bad_par, input logic bad_stop, input logic glitch);
        frame_exp_t f;
        key_exp_t   k;
        if (bad_par || bad_stop) begin
            modelError();
        end else begin
            f.err = 1'b0;
            f.b   = b;
            fq.push_back(f);
            if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else if (b == 8'hE0) begin
                m_ext = 1'b1;
            end else begin
                if (b == 8'h29 && !m_ext) begin
                    m_held = !m_brk;
                end
                k.code = b;
                k.ext  = m_ext;
                k.brk  = m_brk;
                k.flap = (b == 8'h29) && !m_ext && !m_brk;
                k.held = m_held;
                kq.push_back(k);
                m_brk = 1'b0;
                m_ext = 1'b0;
            end
        end
        sendFrameBits(makeFrame(b, bad_par, bad_stop), 11, glitch);
        waitCycles(HALF);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " byte_out"},   32'(byte_out),   32'h0);
        checkOutput({tag, " byte_valid"}, 32'(byte_valid), 32'h0);
        checkOutput({tag, " frame_err"},  32'(frame_err),  32'h0);
        checkOutput({tag, " key_code"},   32'(key_code),   32'h0);
        checkOutput({tag, " key_ext"},    32'(key_ext),    32'h0);
        checkOutput({tag, " key_break"},  32'(key_break),  32'h0);
        checkOutput({tag, " key_valid"},  32'(key_valid),  32'h0);
        checkOutput({tag, " flap_pulse"}, 32'(flap_pulse), 32'h0);
        checkOutput({tag, " space_held"}, 32'(space_held), 32'h0);
    endtask

    // Monitor: decoupled from stimulus, compares each DUT pulse against the queues.
    always @(negedge clk) begin
        frame_exp_t f;
        key_exp_t   k;
        if (byte_valid || frame_err) begin
            if (fq.size() == 0) begin
                reportUnexpected("frame result");
            end else begin
                f = fq.pop_front();
                checkOutput("frame_err", 32'(frame_err), 32'(f.err));
                checkOutput("byte_valid", 32'(byte_valid), 32'(!f.err));
                if (!f.err) begin
                    checkOutput("byte_out", 32'(byte_out), 32'(f.b));
                end
            end
        end
        if (key_valid) begin
            if (kq.size() == 0) begin
                reportUnexpected("key_valid");
            end else begin
                k = kq.pop_front();
                checkOutput("key_code", 32'(key_code), 32'(k.code));
                checkOutput("key_ext", 32'(key_ext), 32'(k.ext));
                checkOutput("key_break", 32'(key_break), 32'(k.brk));
                checkOutput("flap_pulse", 32'(flap_pulse), 32'(k.flap));
                checkOutput("space_held", 32'(space_held), 32'(k.held));
            end
        end else if (flap_pulse) begin
            reportUnexpected("flap_pulse without key_valid");
        end
    end

    initial begin
        logic [7:0] b;
        int         kind;

        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        waitCycles(5);
        rst = 1'b0;
        waitCycles(2);
        checkAllZero("reset");

        $display("[TB] directed frames");
        applyStimulus(8'h29, 1'b0, 1'b0, 1'b0);
        checkOutput("space_held after make", 32'(space_held), 32'h1);
        applyStimulus(8'hF0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h29, 1'b0, 1'b0, 1'b0);
        checkOutput("space_held after break", 32'(space_held), 32'h0);
        applyStimulus(8'hE0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h75, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h29, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h29, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h29, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h3C, 1'b0, 1'b1, 1'b0);

        $display("[TB] bad start bit");
        modelError();
        sendBit(1'b1, 1'b0);
        waitCycles(HALF);

        $display("[TB] timeout");
        applyStimulus(8'hE0, 1'b0, 1'b0, 1'b0);
        modelError();
        sendFrameBits(makeFrame(8'h1C, 1'b0, 1'b0), 5, 1'b0);
        waitCycles(TB_TIMEOUT + 100);
        checkOutput("timeout drained", 32'(fq.size()), 32'h0);
        applyStimulus(8'h1C, 1'b0, 1'b0, 1'b0);

        $display("[TB] clock glitches");
        applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hF0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h29, 1'b0, 1'b0, 1'b1);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h29, 1'b0, 1'b0, 1'b0);
        sendFrameBits(makeFrame(8'hF0, 1'b0, 1'b0), 5, 1'b0);
        rst = 1'b1;
        waitCycles(3);
        rst = 1'b0;
        m_brk  = 1'b0;
        m_ext  = 1'b0;
        m_held = 1'b0;
        waitCycles(2);
        checkAllZero("mid-frame reset");
        applyStimulus(8'h1C, 1'b0, 1'b0, 1'b0);

        $display("[TB] random frames");
        for (int i = 0; i < 50; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 2) begin
                applyStimulus(8'hF0, 1'b0, 1'b0, 1'b0);
            end else if (kind < 4) begin
                applyStimulus(8'hE0, 1'b0, 1'b0, 1'b0);
            end
            b = ($urandom_range(0, 2) == 0) ? 8'h29 : 8'($urandom);
            applyStimulus(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 5) == 0));
        end

        waitCycles(50);
        checkOutput("frame queue drained", 32'(fq.size()), 32'h0);
        checkOutput("key queue drained", 32'(kq.size()), 32'h0);
        checkOutput("space_held final", 32'(space_held), 32'(m_held));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
